// File: rtl/inst_mem_loadable_pkg.sv
// ============================================================================
// inst_mem_loadable_pkg : shared constants and types for the loadable instruction memory
// Revision 1.0
// ============================================================================
`default_nettype none

package inst_mem_loadable_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  typedef logic [0:0] im_state_t;
  localparam im_state_t IM_LOAD = 1'b0;
  localparam im_state_t IM_RUN  = 1'b1;

  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

  typedef logic [1:0] fault_t;

  // Byte 0 is the lowest address and lands in the most significant lane.
  function automatic logic [31:0] be_pack(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_mem_loadable_if.sv
// ============================================================================
// inst_mem_loadable_if : load port and fetch port bundle for inst_mem_loadable
// Revision 1.0
// ============================================================================
`default_nettype none

interface inst_mem_loadable_if #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 1024
);
  localparam int IDX_W = $clog2(DEPTH_BYTES / 4);
  localparam int CNT_W = IDX_W + 1;

  logic              load_en;
  logic [IDX_W-1:0]  load_waddr;
  logic [31:0]       load_data;
  logic              load_done;
  logic [CNT_W-1:0]  loaded_cnt;
  logic              ready;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_stall;
  logic              fetch_flush;
  logic [31:0]       instruction;
  logic              fetch_valid;
  logic [1:0]        fetch_fault;

  modport master (
    output load_en, load_waddr, load_data, load_done,
    output fetch_req, fetch_addr, fetch_stall, fetch_flush,
    input  loaded_cnt, ready, instruction, fetch_valid, fetch_fault
  );

  modport slave (
    input  load_en, load_waddr, load_data, load_done,
    input  fetch_req, fetch_addr, fetch_stall, fetch_flush,
    output loaded_cnt, ready, instruction, fetch_valid, fetch_fault
  );

endinterface

`default_nettype wire

// File: rtl/inst_mem_bank_ram.sv
// ============================================================================
// inst_mem_bank_ram : 4-lane byte RAM, one word-wide sync write, one sync read
// Revision 1.0
// ============================================================================
`default_nettype none

module inst_mem_bank_ram
  import inst_mem_loadable_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  wire logic             clk,
  input  wire logic             wr_en,
  input  wire logic [IDX_W-1:0] wr_idx,
  input  wire logic [31:0]      wr_data,
  input  wire logic             rd_en,
  input  wire logic [IDX_W-1:0] rd_idx,
  output logic      [31:0]      rd_data
);

  logic [7:0] lane_rd [4];

  generate
    for (genvar l = 0; l < 4; l++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_q;
      logic [7:0] rd_d;

      // Read data is held while rd_en is low so a stalled fetch keeps its word.
      always_comb begin
        rd_d = rd_q;
        if (rd_en) rd_d = mem[rd_idx];
      end

      always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data[31-8*l -: 8];
        rd_q <= rd_d;
      end

      assign lane_rd[l] = rd_q;
    end
  endgenerate

  assign rd_data = be_pack(lane_rd[0], lane_rd[1], lane_rd[2], lane_rd[3]);

endmodule

`default_nettype wire

// File: rtl/inst_mem_loadable.sv
// ============================================================================
// inst_mem_loadable : loadable big-endian instruction memory with stall/flush fetch port
// Revision 1.0
// ============================================================================
`default_nettype none

module inst_mem_loadable
  import inst_mem_loadable_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int INSN_W      = 32
) (
  input wire logic clk,
  input wire logic rst,
  inst_mem_loadable_if.slave bus
);

  localparam int DEPTH_WORDS = DEPTH_BYTES / 4;
  localparam int IDX_W       = $clog2(DEPTH_WORDS);
  localparam int CNT_W       = IDX_W + 1;
  localparam logic [ADDR_W-1:0] DEPTH_LIMIT = ADDR_W'(DEPTH_BYTES);
  localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(DEPTH_WORDS);

  generate
    if (INSN_W != 32) begin : g_bad_insn_w
      $error("inst_mem_loadable: INSN_W must be 32");
    end
    if ((DEPTH_BYTES < 8) || ((DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0)) begin : g_bad_depth
      $error("inst_mem_loadable: DEPTH_BYTES must be a power of 2 and >= 8");
    end
  endgenerate

  im_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             use_ram_q, use_ram_d;
  logic             valid_q, valid_d;
  fault_t           fault_q, fault_d;

  logic             load_accept;
  logic             run;
  logic             rd_en;
  fault_t           fault_now;
  logic [31:0]      ram_rdata;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IM_LOAD;
    else     state_q <= state_d;
  end

  // RUN is terminal; only rst brings the block back to LOAD.
  always_comb begin
    state_d = state_q;
    if (state_q == IM_LOAD && bus.load_done) state_d = IM_RUN;
  end

  always_comb begin
    run         = (state_q == IM_RUN);
    load_accept = (state_q == IM_LOAD) && bus.load_en;
    bus.ready   = run;
  end

  always_comb begin
    fault_now                 = '0;
    fault_now[FAULT_MISALIGN] = |bus.fetch_addr[1:0];
    fault_now[FAULT_RANGE]    = (bus.fetch_addr >= DEPTH_LIMIT);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_accept && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
  end

  // Fetch priority: stall holds everything, then flush, then request, else idle.
  always_comb begin
    use_ram_d = 1'b0;
    valid_d   = 1'b0;
    fault_d   = '0;
    rd_en     = 1'b0;
    if (run) begin
      if (bus.fetch_stall) begin
        use_ram_d = use_ram_q;
        valid_d   = valid_q;
        fault_d   = fault_q;
      end else if (bus.fetch_flush) begin
        valid_d = 1'b1;
      end else if (bus.fetch_req) begin
        valid_d   = 1'b1;
        fault_d   = fault_now;
        use_ram_d = (fault_now == '0);
        rd_en     = (fault_now == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      use_ram_q <= 1'b0;
      valid_q   <= 1'b0;
      fault_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      use_ram_q <= use_ram_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
    end
  end

  inst_mem_bank_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (load_accept),
    .wr_idx  (bus.load_waddr),
    .wr_data (bus.load_data),
    .rd_en   (rd_en),
    .rd_idx  (bus.fetch_addr[IDX_W+1:2]),
    .rd_data (ram_rdata)
  );

  always_comb begin
    bus.instruction = use_ram_q ? ram_rdata : NOP_INSN;
    bus.fetch_valid = valid_q;
    bus.fetch_fault = fault_q;
    bus.loaded_cnt  = cnt_q;
  end

endmodule

`default_nettype wire
